// File: rtl/shift_register_mc_if.sv
// shift_register_mc_if: control, data and observation bundle for shift_register_mc.
//   master: drives en/flush/mode/d/d_valid/load_data/tap_sel, observes the outputs.
//   slave : the shift register itself.
// Packed buses put stage i at bits [i*WIDTH +: WIDTH].
interface shift_register_mc_if #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int SEL_W = 4
);
  logic                   en;
  logic                   flush;
  logic [1:0]             mode;
  logic [WIDTH-1:0]       d;
  logic                   d_valid;
  logic [DEPTH*WIDTH-1:0] load_data;
  logic [SEL_W-1:0]       tap_sel;

  logic [WIDTH-1:0]       q_last;
  logic [WIDTH-1:0]       q_first;
  logic                   vld_last;
  logic                   vld_first;
  logic [WIDTH-1:0]       q_tap;
  logic [DEPTH*WIDTH-1:0] q_all;
  logic [SEL_W:0]         count;

  modport master (
    output en, flush, mode, d, d_valid, load_data, tap_sel,
    input  q_last, q_first, vld_last, vld_first, q_tap, q_all, count
  );

  modport slave (
    input  en, flush, mode, d, d_valid, load_data, tap_sel,
    output q_last, q_first, vld_last, vld_first, q_tap, q_all, count
  );
endinterface

// File: rtl/shift_register_mc.sv
// shift_register_mc: multi-mode shift register with per-stage valid bits.
//   Modes (when en=1): 00 shift forward (d enters stage 0), 01 shift reverse
//   (d enters stage DEPTH-1), 10 rotate forward, 11 parallel load (all valid).
//   flush clears data and valids and beats en. q_tap is a registered copy of
//   stage tap_sel, updated every edge; out-of-range selects give 0.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   bus        : shift_register_mc_if.slave (controls, data, outputs)

// One stage: data word plus valid bit. The parent picks the neighbours.
module shift_register_mc_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] fwd_d,   // lower neighbour (or head source)
  input  logic             fwd_v,
  input  logic [WIDTH-1:0] rev_d,   // upper neighbour (or d at the tail)
  input  logic             rev_v,
  input  logic [WIDTH-1:0] ld_d,
  output logic [WIDTH-1:0] q,
  output logic             v
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
      v <= 1'b0;
    end else if (flush) begin
      q <= '0;
      v <= 1'b0;
    end else if (en) begin
      case (mode)
        2'b01: begin
          q <= rev_d;
          v <= rev_v;
        end
        2'b11: begin
          q <= ld_d;
          v <= 1'b1;
        end
        // forward shift and rotate move the same way; only the head source differs
        default: begin
          q <= fwd_d;
          v <= fwd_v;
        end
      endcase
    end
  end
endmodule

module shift_register_mc #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int SEL_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  shift_register_mc_if.slave   bus
);
  localparam logic [1:0] MODE_ROT = 2'b10;
  localparam int         TAPS     = 1 << SEL_W;

  if (DEPTH < 2 || DEPTH > 256 || WIDTH < 1 || TAPS < DEPTH) begin : g_bad_cfg
    $error("shift_register_mc: illegal DEPTH/WIDTH/SEL_W combination");
  end

  logic [DEPTH-1:0][WIDTH-1:0] core;
  logic [DEPTH-1:0]            vld;
  logic [WIDTH-1:0]            head_d;
  logic                        head_v;
  logic [TAPS-1:0][WIDTH-1:0]  tap_arr;
  logic [WIDTH-1:0]            q_tap;
  logic [SEL_W:0]              count;

  // Rotate recirculates the tail into stage 0 instead of taking d.
  assign head_d = (bus.mode == MODE_ROT) ? core[DEPTH-1] : bus.d;
  assign head_v = (bus.mode == MODE_ROT) ? vld[DEPTH-1]  : bus.d_valid;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] fwd_d;
    logic [WIDTH-1:0] rev_d;
    logic             fwd_v;
    logic             rev_v;

    if (i == 0) begin : g_head
      assign fwd_d = head_d;
      assign fwd_v = head_v;
    end else begin : g_fwd
      assign fwd_d = core[i-1];
      assign fwd_v = vld[i-1];
    end

    if (i == DEPTH-1) begin : g_tail
      assign rev_d = bus.d;
      assign rev_v = bus.d_valid;
    end else begin : g_rev
      assign rev_d = core[i+1];
      assign rev_v = vld[i+1];
    end

    shift_register_mc_stage #(.WIDTH(WIDTH)) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (bus.en),
      .flush (bus.flush),
      .mode  (bus.mode),
      .fwd_d (fwd_d),
      .fwd_v (fwd_v),
      .rev_d (rev_d),
      .rev_v (rev_v),
      .ld_d  (bus.load_data[i*WIDTH +: WIDTH]),
      .q     (core[i]),
      .v     (vld[i])
    );
  end

  // Tap table padded to the full select range so tap_sel never indexes past core.
  for (genvar t = 0; t < TAPS; t++) begin : g_tap
    if (t < DEPTH) begin : g_real
      assign tap_arr[t] = core[t];
    end else begin : g_pad
      assign tap_arr[t] = '0;
    end
  end

  // Samples pre-edge core every cycle; deliberately ignores en and flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_tap <= '0;
    else        q_tap <= tap_arr[bus.tap_sel];
  end

  always_comb begin
    count = '0;
    for (int k = 0; k < DEPTH; k++) count = count + (SEL_W+1)'(vld[k]);
  end

  assign bus.q_all     = core;
  assign bus.q_first   = core[0];
  assign bus.q_last    = core[DEPTH-1];
  assign bus.vld_first = vld[0];
  assign bus.vld_last  = vld[DEPTH-1];
  assign bus.q_tap     = q_tap;
  assign bus.count     = count;
endmodule

// File: tb/tb_shift_register_mc.sv
module tb_shift_register_mc;
  localparam int DEPTH = 4;
  localparam int WIDTH = 8;
  localparam int SEL_W = 2;
  localparam logic [1:0] FWD = 2'b00, REV = 2'b01, ROT = 2'b10, LD = 2'b11;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic chk_on = 1'b0;
  int   tests = 0;
  int   fails = 0;

  shift_register_mc_if #(.DEPTH(DEPTH), .WIDTH(WIDTH), .SEL_W(SEL_W)) bus ();

  shift_register_mc #(.DEPTH(DEPTH), .WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: queues indexed by stage number; shifting is push at one end, pop at the other.
  logic [WIDTH-1:0] md[$];
  bit               mv[$];
  logic [WIDTH-1:0] mtap;

  function automatic void clear_core();
    md = {};
    mv = {};
    for (int i = 0; i < DEPTH; i++) begin
      md.push_back('0);
      mv.push_back(1'b0);
    end
  endfunction

  function automatic void model_reset();
    clear_core();
    mtap = '0;
  endfunction

  function automatic logic [DEPTH*WIDTH-1:0] model_all();
    logic [DEPTH*WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < DEPTH; i++) r[i*WIDTH +: WIDTH] = md[i];
    return r;
  endfunction

  function automatic int model_cnt();
    int c;
    c = 0;
    foreach (mv[i]) c += int'(mv[i]);
    return c;
  endfunction

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      mtap = (int'(bus.tap_sel) < DEPTH) ? md[bus.tap_sel] : '0;
      if (bus.flush) begin
        clear_core();
      end else if (bus.en) begin
        case (bus.mode)
          FWD: begin
            md.push_front(bus.d);       void'(md.pop_back());
            mv.push_front(bus.d_valid); void'(mv.pop_back());
          end
          REV: begin
            md.push_back(bus.d);        void'(md.pop_front());
            mv.push_back(bus.d_valid);  void'(mv.pop_front());
          end
          ROT: begin
            md.push_front(md.pop_back());
            mv.push_front(mv.pop_back());
          end
          default: begin
            for (int i = 0; i < DEPTH; i++) begin
              md[i] = bus.load_data[i*WIDTH +: WIDTH];
              mv[i] = 1'b1;
            end
          end
        endcase
      end
    end
  end

  // Every-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("cyc_q_all",     bus.q_all,     model_all());
      chk("cyc_q_first",   bus.q_first,   md[0]);
      chk("cyc_q_last",    bus.q_last,    md[DEPTH-1]);
      chk("cyc_vld_first", bus.vld_first, mv[0]);
      chk("cyc_vld_last",  bus.vld_last,  mv[DEPTH-1]);
      chk("cyc_count",     bus.count,     model_cnt());
      chk("cyc_q_tap",     bus.q_tap,     mtap);
    end
  end

  task automatic step(input logic e, input logic f, input logic [1:0] m,
                      input logic [7:0] dd, input logic dv,
                      input logic [31:0] ld, input logic [1:0] ts);
    bus.en = e; bus.flush = f; bus.mode = m; bus.d = dd; bus.d_valid = dv;
    bus.load_data = ld; bus.tap_sel = ts;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, FWD, 8'h00, 1'b0, 32'h0, 2'd0);
  endtask

  logic [7:0] tap_exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    model_reset();
    rst_n = 1'b0;
    bus.en = 1'b1; bus.flush = 1'b0; bus.mode = 2'($urandom_range(0, 3));
    bus.d = 8'($urandom()); bus.d_valid = 1'b1; bus.load_data = $urandom();
    bus.tap_sel = 2'($urandom_range(0, 3));
    repeat (3) @(negedge clk);
    chk("rst_q_all", bus.q_all, 32'h0);
    chk("rst_count", bus.count, 3'd0);
    chk("rst_q_tap", bus.q_tap, 8'h00);
    bus.en = 1'b0; bus.mode = FWD; bus.d_valid = 1'b0;
    rst_n = 1'b1;
    chk_on = 1'b1;

    // forward shift
    step(1, 0, FWD, 8'h11, 1, 0, 0);
    step(1, 0, FWD, 8'h22, 1, 0, 0);
    step(1, 0, FWD, 8'h33, 1, 0, 0);
    step(1, 0, FWD, 8'h44, 1, 0, 0);
    chk("fwd_q_last", bus.q_last, 8'h11);
    chk("fwd_vld_last", bus.vld_last, 1'b1);
    chk("fwd_count", bus.count, 3'd4);
    chk("fwd_q_all", bus.q_all, 32'h11223344);
    chk("mdl_fwd_all", model_all(), 32'h11223344);

    // stalls and valid gaps, starting from empty
    step(0, 1, FWD, 8'h00, 0, 0, 0);
    chk("flush_count", bus.count, 3'd0);
    step(1, 0, FWD, 8'hA1, 1, 0, 0);
    chk("gap_count1", bus.count, 3'd1);
    idle(); idle();
    chk("stall_q_all", bus.q_all, 32'h000000A1);
    step(1, 0, FWD, 8'hB2, 0, 0, 0);
    chk("gap_count2", bus.count, 3'd1);
    idle(); idle();
    step(1, 0, FWD, 8'hC3, 1, 0, 0);
    chk("gap_count3", bus.count, 3'd2);
    chk("gap_q_all", bus.q_all, 32'h00A1B2C3);
    chk("gap_vld", dut.vld[2:0], 3'b101);
    chk("mdl_gap_vld", {mv[2], mv[1], mv[0]}, 3'b101);

    // load then rotate
    step(1, 0, LD, 8'h00, 0, 32'hDDCCBBAA, 0);
    chk("ld_count", bus.count, 3'd4);
    chk("ld_q_first", bus.q_first, 8'hAA);
    step(1, 0, ROT, 8'h5A, 0, 0, 0);
    chk("rot1_q_all", bus.q_all, 32'hCCBBAADD);
    chk("mdl_rot1_all", model_all(), 32'hCCBBAADD);
    repeat (4) step(1, 0, ROT, 8'h00, 0, 0, 0);
    chk("rot5_q_all", bus.q_all, 32'hCCBBAADD);
    chk("rot5_count", bus.count, 3'd4);

    // reverse shift
    step(1, 0, LD, 8'h00, 0, 32'h44332211, 0);
    step(1, 0, REV, 8'h55, 0, 0, 0);
    chk("rev_q_all", bus.q_all, 32'h55443322);
    chk("rev_vld_last", bus.vld_last, 1'b0);
    chk("rev_count", bus.count, 3'd3);

    // tap sweep, then select change together with a shift
    step(1, 0, LD, 8'h00, 0, 32'h44332211, 0);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, FWD, 8'h00, 0, 0, 2'(k));
      chk("tap_sweep", bus.q_tap, tap_exp[k]);
    end
    step(1, 0, FWD, 8'h99, 1, 0, 2'd0);
    chk("tap_preshift", bus.q_tap, 8'h11);
    chk("tap_q_first", bus.q_first, 8'h99);

    // flush beats en+LOAD
    step(1, 1, LD, 8'h00, 1, 32'hFFFFFFFF, 0);
    chk("flush_q_all", bus.q_all, 32'h0);
    chk("flush_count2", bus.count, 3'd0);

    // asynchronous reset mid-shift
    step(1, 0, FWD, 8'h5A, 1, 0, 0);
    step(1, 0, FWD, 8'h6B, 1, 0, 1);
    chk("pre_rst_q_all", bus.q_all, 32'h00005A6B);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_q_all", bus.q_all, 32'h0);
    chk("arst_count", bus.count, 3'd0);
    chk("arst_q_tap", bus.q_tap, 8'h00);
    chk("arst_vld_first", bus.vld_first, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    step(1, 0, FWD, 8'h77, 1, 0, 0);
    chk("post_rst_q_first", bus.q_first, 8'h77);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
